p14_flappy_renderer: RTL and testbench

//  VGA 640x480@60 timing generator and pixel renderer for the flappy game; sink of the game-control state bus.

---
 rtl/p14_flappy_pkg.sv | 14 +
 rtl/p14_flappy_renderer_if.sv | 10 +
 rtl/p14_bin2bcd_seq.sv | 42 ++++
 rtl/p14_flappy_renderer.sv | 99 +++++++++
 tb/tb_p14_flappy_renderer.sv | 129 ++++++++++++
 5 files changed

// File: rtl/p14_flappy_pkg.sv
// p14_flappy_pkg: VGA timing, colours, 3x5 digit font and converter state shared by the flappy VGA blocks
package p14_flappy_pkg;
  localparam logic [10:0] H_VIS = 11'd640, H_SYNC_S = 11'd656, H_SYNC_E = 11'd752, H_TOTAL = 11'd800;
  localparam logic [10:0] V_VIS = 11'd480, V_SYNC_S = 11'd490, V_SYNC_E = 11'd492, V_TOTAL = 11'd525;
  localparam logic [5:0] C_SCORE = 6'b111111, C_BIRD = 6'b111100, C_PIPE = 6'b001100, C_SKY = 6'b000111;
  localparam logic [0:9][0:14] FONT = {
    15'b111_101_101_101_111, 15'b010_110_010_010_111, 15'b111_001_111_100_111, 15'b111_001_111_001_111,
    15'b101_101_111_001_001, 15'b111_100_111_001_111, 15'b111_100_111_101_111, 15'b111_001_001_001_001,
    15'b111_101_111_101_111, 15'b111_101_111_001_111};
  typedef enum logic {BCD_IDLE, BCD_BUSY} bcd_state_e;
  function automatic logic font_px(input logic [3:0] dig, input logic [10:0] dx, input logic [10:0] dy);
    return dig <= 4'd9 && dx < 11'd12 && dy < 11'd20 && FONT[dig][4'((dy >> 2) * 11'd3 + (dx >> 2))];
  endfunction
endpackage

// File: rtl/p14_flappy_renderer_if.sv
// p14_flappy_renderer_if: game-control state bus from the game logic to the renderer
interface p14_flappy_renderer_if;
  logic [8:0] bird_pos;
  logic [8:0] hole_pos;
  logic [9:0] pipe_pos;
  logic [7:0] score;
  logic game_v_sync;
  modport master (output bird_pos, hole_pos, pipe_pos, score, input game_v_sync);
  modport slave (input bird_pos, hole_pos, pipe_pos, score, output game_v_sync);
endinterface

// File: rtl/p14_bin2bcd_seq.sv
// p14_bin2bcd_seq: sequential double-dabble, one shift per clock, 8-bit binary to 3 BCD digits
module p14_bin2bcd_seq
  import p14_flappy_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [7:0] bin,
  output logic busy,
  output logic done,
  output logic [11:0] bcd
);
  bcd_state_e state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [11:0] acc_q, acc_d, adj;
  logic [2:0] cnt_q, cnt_d;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    busy = state_q == BCD_BUSY;
    done = busy && cnt_q == 3'd7;
    bcd = 12'({adj, sh_q[7]});
    state_d = start ? BCD_BUSY : done ? BCD_IDLE : state_q;
    sh_d = start ? bin : busy ? {sh_q[6:0], 1'b0} : sh_q;
    acc_d = start ? '0 : busy ? bcd : acc_q;
    cnt_d = start ? '0 : busy ? cnt_q + 3'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BCD_IDLE;
      sh_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/p14_flappy_renderer.sv
// p14_flappy_renderer: VGA timing generator with per-frame shadow latch drawing sky, pipe, bird and 3-digit score
module p14_flappy_renderer
  import p14_flappy_pkg::*;
#(
  parameter logic [10:0] BIRD_X = 11'd100,
  parameter logic [10:0] BIRD_SIZE = 11'd16,
  parameter logic [10:0] PIPE_W = 11'd64,
  parameter logic [10:0] GAP_LO = 11'd50,
  parameter logic [10:0] GAP_HI = 11'd150,
  parameter logic [10:0] SCORE_X = 11'd8,
  parameter logic [10:0] SCORE_Y = 11'd8,
  parameter logic [10:0] HV = H_VIS,
  parameter logic [10:0] HSS = H_SYNC_S,
  parameter logic [10:0] HSE = H_SYNC_E,
  parameter logic [10:0] HT = H_TOTAL,
  parameter logic [10:0] VV = V_VIS,
  parameter logic [10:0] VSS = V_SYNC_S,
  parameter logic [10:0] VSE = V_SYNC_E,
  parameter logic [10:0] VT = V_TOTAL
) (
  input  logic clk,
  input  logic rst,
  p14_flappy_renderer_if.slave bus,
  output logic hsync,
  output logic vsync,
  output logic display_on,
  output logic [5:0] rgb
);
  logic [10:0] h_q, h_d, v_q, v_d, bird_y, hole_y, pipe_x;
  logic [8:0] bird_q, bird_d, hole_q, hole_d;
  logic [9:0] pipe_q, pipe_d;
  logic [7:0] score_q, score_d;
  logic [11:0] dig_q, dig_d, bcd;
  logic [5:0] rgb_q, rgb_d;
  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, gvs_q, gvs_d;
  logic latch, vis, pipe_px, bird_px, score_px, bcd_busy, bcd_done;
  p14_bin2bcd_seq u_bcd (
    .clk(clk), .rst(rst), .start(latch && !bcd_busy), .bin(score_d),
    .busy(bcd_busy), .done(bcd_done), .bcd(bcd)
  );
  always_comb begin
    latch = h_q == '0 && v_q == VT - 11'd1;
    h_d = h_q == HT - 11'd1 ? '0 : h_q + 11'd1;
    v_d = h_q != HT - 11'd1 ? v_q : v_q == VT - 11'd1 ? '0 : v_q + 11'd1;
    bird_d = latch ? bus.bird_pos : bird_q;
    hole_d = latch ? bus.hole_pos : hole_q;
    pipe_d = latch ? bus.pipe_pos : pipe_q;
    score_d = latch ? bus.score : score_q;
    dig_d = bcd_done ? bcd : dig_q;
    bird_y = {2'b0, bird_q};
    hole_y = {2'b0, hole_q};
    pipe_x = {1'b0, pipe_q};
    vis = h_q < HV && v_q < VV;
    pipe_px = h_q < pipe_x && h_q + PIPE_W >= pipe_x && !(v_q > hole_y + GAP_LO && v_q < hole_y + GAP_HI);
    bird_px = h_q >= BIRD_X && h_q < BIRD_X + BIRD_SIZE && v_q >= bird_y && v_q < bird_y + BIRD_SIZE;
    score_px = 1'b0;
    for (int d = 0; d < 3; d++)
      score_px = score_px | font_px(dig_q[4*(2-d) +: 4], h_q - SCORE_X - 11'(16*d), v_q - SCORE_Y);
    rgb_d = !vis ? '0 : score_px ? C_SCORE : bird_px ? C_BIRD : pipe_px ? C_PIPE : C_SKY;
    hs_d = !(h_q >= HSS && h_q < HSE);
    vs_d = !(v_q >= VSS && v_q < VSE);
    de_d = vis;
    gvs_d = v_q < VV;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      bird_q <= 9'd265;
      hole_q <= 9'd165;
      pipe_q <= 10'd600;
      score_q <= '0;
      dig_q <= '0;
      rgb_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      gvs_q <= 1'b1;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      bird_q <= bird_d;
      hole_q <= hole_d;
      pipe_q <= pipe_d;
      score_q <= score_d;
      dig_q <= dig_d;
      rgb_q <= rgb_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      gvs_q <= gvs_d;
    end
  end
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign display_on = de_q;
  assign rgb = rgb_q;
  assign bus.game_v_sync = gvs_q;
endmodule

// File: tb/tb_p14_flappy_renderer.sv
// tb_p14_flappy_renderer: scoreboard bench, full-size and shrunken-timing renderers against a pixel-rule model
module tb_p14_flappy_renderer;
  typedef struct packed { int hv, hss, hse, ht, vv, vss, vse, vt; } tcfg_t;
  typedef struct packed { int bird, hole, pipe, score; } shd_t;
  localparam tcfg_t CS = '{128, 136, 148, 160, 64, 70, 72, 80};
  localparam tcfg_t CF = '{640, 656, 752, 800, 480, 490, 492, 525};
  localparam shd_t SH0 = '{265, 165, 600, 0};
  localparam logic [9:0] RST_OUT = 10'b11_0_1_000000;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int n_s = 0, n_f = 0;
  shd_t sh_s = SH0, sh_f = SH0;
  logic [9:0] q_s[$], q_f[$];
  logic [8:0] bird_in = 9'd265, hole_in = 9'd165;
  logic [9:0] pipe_in = 10'd600;
  logic [7:0] score_in = 8'd0;
  logic hs_s, vs_s, de_s, hs_f, vs_f, de_f;
  logic [5:0] rgb_s, rgb_f;
  string font[10] = '{"####.##.##.####", ".#.##..#..#.###", "###..#####..###", "###..####..####",
                      "#.##.####..#..#", "####..###..####", "####..####.####", "###..#..#..#..#",
                      "####.#####.####", "####.####..####"};
  p14_flappy_renderer_if bus_s ();
  p14_flappy_renderer_if bus_f ();
  assign bus_s.bird_pos = bird_in;
  assign bus_s.hole_pos = hole_in;
  assign bus_s.pipe_pos = pipe_in;
  assign bus_s.score = score_in;
  assign bus_f.bird_pos = bird_in;
  assign bus_f.hole_pos = hole_in;
  assign bus_f.pipe_pos = pipe_in;
  assign bus_f.score = score_in;
  p14_flappy_renderer #(.HV(11'd128), .HSS(11'd136), .HSE(11'd148), .HT(11'd160),
                        .VV(11'd64), .VSS(11'd70), .VSE(11'd72), .VT(11'd80)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .hsync(hs_s), .vsync(vs_s), .display_on(de_s), .rgb(rgb_s));
  p14_flappy_renderer dut_f (
    .clk(clk), .rst(rst), .bus(bus_f), .hsync(hs_f), .vsync(vs_f), .display_on(de_f), .rgb(rgb_f));
  function automatic logic [9:0] model(input tcfg_t c, input shd_t s, input int n);
    int x, y, dg;
    logic [5:0] col;
    logic de;
    x = n % c.ht;
    y = n / c.ht % c.vt;
    col = 6'b000111;
    if (x < s.pipe && x + 64 >= s.pipe && !(y > s.hole + 50 && y < s.hole + 150)) col = 6'b001100;
    if (x >= 100 && x < 116 && y >= s.bird && y < s.bird + 16) col = 6'b111100;
    for (int d = 0; d < 3; d++) begin
      dg = d == 0 ? s.score / 100 : d == 1 ? s.score / 10 % 10 : s.score % 10;
      if (x >= 8 + 16 * d && x < 20 + 16 * d && y >= 8 && y < 28)
        if (font[dg][(y - 8) / 4 * 3 + (x - 8 - 16 * d) / 4] == "#") col = 6'b111111;
    end
    de = x < c.hv && y < c.vv;
    return {!(x >= c.hss && x < c.hse), !(y >= c.vss && y < c.vse), de, y < c.vv, de ? col : 6'b0};
  endfunction
  task automatic step(input tcfg_t c, inout shd_t s, inout int n, output logic [9:0] e);
    if (rst) begin
      s = SH0;
      n = 0;
      e = RST_OUT;
    end else begin
      e = model(c, s, n);
      if (n % c.ht == 0 && n / c.ht % c.vt == c.vt - 1)
        s = '{int'(bird_in), int'(hole_in), int'(pipe_in), int'(score_in)};
      n++;
    end
  endtask
  task automatic cmp(input string nm, input int n, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s n=%0d actual=%h required=%h", nm, n, act, exp);
    end
  endtask
  task automatic rand_in();
    bird_in = $urandom_range(0, 3) == 0 ? 9'd480 : 9'($urandom_range(0, 70));
    hole_in = 9'($urandom_range(0, 20));
    case ($urandom_range(0, 5))
      0: pipe_in = 10'd0;
      1: pipe_in = 10'd20;
      2: pipe_in = 10'd191;
      3: pipe_in = 10'd192;
      4: pipe_in = 10'd1023;
      default: pipe_in = 10'($urandom_range(1, 200));
    endcase
    score_in = 8'($urandom_range(0, 255));
  endtask
  initial begin : scoreboard_push
    logic [9:0] e;
    forever begin
      @(posedge clk);
      if (!rst && n_s % CS.ht == 9 && n_s / CS.ht % CS.vt == CS.vt - 1)
        cmp("bcd_digits", n_s, dut_s.dig_q,
            {4'(sh_s.score / 100), 4'(sh_s.score / 10 % 10), 4'(sh_s.score % 10)});
      step(CS, sh_s, n_s, e);
      q_s.push_back(e);
      step(CF, sh_f, n_f, e);
      q_f.push_back(e);
    end
  end
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q_s.size() != 0) cmp("pix_small", n_s, {2'b0, hs_s, vs_s, de_s, bus_s.game_v_sync, rgb_s}, {2'b0, q_s.pop_front()});
      if (q_f.size() != 0) cmp("pix_full", n_f, {2'b0, hs_f, vs_f, de_f, bus_f.game_v_sync, rgb_f}, {2'b0, q_f.pop_front()});
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3200) @(negedge clk);
    {bird_in, hole_in, pipe_in, score_in} = {9'd20, 9'd5, 10'd20, 8'd255};
    repeat (12800) @(negedge clk);
    {bird_in, hole_in, pipe_in, score_in} = {9'd60, 9'd0, 10'd180, 8'd9};
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12800) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rand_in();
      repeat (6400) @(negedge clk);
      rand_in();
      repeat (6400) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
